// File: rtl/glyph_serializer.sv
// Glyph serializer: latches a character, samples its bitmap from an external glyph source,
// and streams SCALE-replicated pixels row-major. Optional GLYPH_INVERT_EN adds in_invert.
module glyph_serializer #(
  parameter int FONT_W = 8,
  parameter int FONT_H = 16,
  parameter int SCALE  = 1,
  localparam int NB = FONT_W * FONT_H,
  localparam int CW = (FONT_W * SCALE > 1) ? $clog2(FONT_W * SCALE) : 1,
  localparam int RW = (FONT_H * SCALE > 1) ? $clog2(FONT_H * SCALE) : 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [6:0]    in_char,
  input  logic          in_valid,
`ifdef GLYPH_INVERT_EN
  input  logic          in_invert,
`endif
  output logic          in_ready,
  output logic [6:0]    glyph_char,
  input  logic [NB-1:0] glyph_bits,
  output logic          px_data,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [CW-1:0] px_col,
  output logic [RW-1:0] px_row,
  output logic          px_eol,
  output logic          px_last
);

  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(FONT_W * SCALE - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(FONT_H * SCALE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [6:0]    char_q, char_d;
  logic [NB-1:0] bitmap_q, bitmap_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          inv_q, inv_d;
  logic          in_inv;
  logic [IW-1:0] bit_idx;
  int            lin_idx;

`ifdef GLYPH_INVERT_EN
  assign in_inv = in_invert;
`else
  assign in_inv = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    char_d   = char_q;
    bitmap_d = bitmap_q;
    col_d    = col_q;
    row_d    = row_q;
    inv_d    = inv_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          char_d  = in_char;
          inv_d   = in_inv;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bitmap_d = glyph_bits;
        col_d    = '0;
        row_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (px_ready) begin
          if (col_q == COL_MAX) begin
            col_d = '0;
            if (row_q == ROW_MAX) begin
              row_d   = '0;
              state_d = IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output counters run at the scaled resolution; dividing by SCALE maps back to the source bit.
  always_comb begin
    lin_idx = (int'(row_q) / SCALE) * FONT_W + int'(col_q) / SCALE;
    bit_idx = IW'(NB - 1 - lin_idx);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      char_q   <= '0;
      bitmap_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      char_q   <= char_d;
      bitmap_q <= bitmap_d;
      col_q    <= col_d;
      row_q    <= row_d;
      inv_q    <= inv_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign px_valid   = (state_q == SHIFT);
  assign glyph_char = char_q;
  assign px_col     = col_q;
  assign px_row     = row_q;
  assign px_data    = px_valid & (bitmap_q[bit_idx] ^ inv_q);
  assign px_eol     = px_valid & (col_q == COL_MAX);
  assign px_last    = px_eol & (row_q == ROW_MAX);

endmodule

// File: tb/tb_glyph_serializer.sv
// Bench for glyph_serializer: vector table plus pixel scoreboard on a SCALE=1 instance,
// and a SCALE=2 instance checked against an index-derived model.
module tb_glyph_serializer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetn = 1'b1;
  logic [6:0]    in_char = '0;
  logic          in_valid = 1'b0;
  logic          in_invert = 1'b0;
  logic          in_ready;
  logic [6:0]    glyph_char;
  logic [127:0]  glyph_bits;
  logic          px_data, px_valid;
  logic          px_ready = 1'b1;
  logic [2:0]    px_col;
  logic [3:0]    px_row;
  logic          px_eol, px_last;
  logic          ready_mode = 1'b0;

  logic [6:0]    in_char2 = '0;
  logic          in_valid2 = 1'b0;
  logic          in_ready2;
  logic [6:0]    glyph_char2;
  logic [127:0]  glyph_bits2;
  logic          px_data2, px_valid2;
  logic          px_ready2 = 1'b1;
  logic [3:0]    px_col2;
  logic [4:0]    px_row2;
  logic          px_eol2, px_last2;

  glyph_serializer #(.FONT_W(8), .FONT_H(16), .SCALE(1)) dut (
    .clock(clock), .resetn(resetn), .in_char(in_char), .in_valid(in_valid),
`ifdef GLYPH_INVERT_EN
    .in_invert(in_invert),
`endif
    .in_ready(in_ready), .glyph_char(glyph_char), .glyph_bits(glyph_bits),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_col(px_col), .px_row(px_row), .px_eol(px_eol), .px_last(px_last)
  );

  glyph_serializer #(.FONT_W(8), .FONT_H(16), .SCALE(2)) dut2 (
    .clock(clock), .resetn(resetn), .in_char(in_char2), .in_valid(in_valid2),
`ifdef GLYPH_INVERT_EN
    .in_invert(1'b0),
`endif
    .in_ready(in_ready2), .glyph_char(glyph_char2), .glyph_bits(glyph_bits2),
    .px_data(px_data2), .px_valid(px_valid2), .px_ready(px_ready2),
    .px_col(px_col2), .px_row(px_row2), .px_eol(px_eol2), .px_last(px_last2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s actual=expired expected=event t=%0t", name, $time);
  endtask

  // Reference font: arbitrary per-code rows, 'A' row 2 = 0x38, space blank.
  function automatic logic [127:0] font(input logic [6:0] c);
    logic [127:0] b;
    logic [7:0]   rb;
    b = '0;
    if (c != 7'h20) begin
      for (int r = 0; r < 16; r++) begin
        rb = 8'(32'(c) * 3 + r * 17);
        if (c == 7'h41 && r == 2) rb = 8'h38;
        b[127 - 8*r -: 8] = rb;
      end
    end
    return b;
  endfunction

  assign glyph_bits  = font(glyph_char);
  assign glyph_bits2 = {1'b1, 127'b0};

  always @(posedge clock) begin
    #1;
    px_ready = ready_mode ? ~px_ready : 1'b1;
  end

  typedef struct packed {
    logic       d;
    logic [2:0] col;
    logic [3:0] row;
    logic       eol;
    logic       last;
  } px_t;

  px_t exp_q[$];
  px_t act;

  task automatic push_glyph(input logic [6:0] c, input logic inv);
    logic [127:0] b;
    px_t e;
    b = font(c);
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 8; k++) begin
        e.d    = b[127 - (r*8 + k)] ^ inv;
        e.col  = 3'(k);
        e.row  = 4'(r);
        e.eol  = (k == 7);
        e.last = (k == 7) && (r == 15);
        exp_q.push_back(e);
      end
  endtask

  int cyc = 0;
  always @(posedge clock) cyc++;

  int acc_cnt = 0, acc_cyc = 0, first_cyc = 0, last_cyc = 0, prev_last_cyc = 0;
  int pix_cnt = 0, last_cnt = 0, ones_cnt = 0, busy_ready = 0;
  int first_row = -1, first_col = -1;
  logic seen_first = 1'b0;
  logic [127:0] cap = '0;

  always @(negedge clock) begin
    if (resetn) begin
      if (in_ready && exp_q.size() != 0) busy_ready++;
      if (in_valid && in_ready) begin
        push_glyph(in_char, in_invert);
        acc_cnt++;
        acc_cyc = cyc;
        prev_last_cyc = last_cyc;
        seen_first = 1'b0;
        pix_cnt = 0;
        last_cnt = 0;
        ones_cnt = 0;
        cap = '0;
      end
      if (px_valid) begin
        if (!seen_first) begin
          seen_first = 1'b1;
          first_cyc = cyc;
          first_row = int'(px_row);
          first_col = int'(px_col);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_pixel actual=row%0d/col%0d expected=no_pixel t=%0t", px_row, px_col, $time);
        end else begin
          act = {px_data, px_col, px_row, px_eol, px_last};
          check("pixel", 32'(act), 32'(exp_q[0]));
          if (px_ready) begin
            if (exp_q[0].last) last_cyc = cyc;
            if (px_last) last_cnt++;
            if (px_data) ones_cnt++;
            if (pix_cnt < 128) cap[pix_cnt] = px_data;
            pix_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  int pix2 = 0, eol2 = 0;
  always @(negedge clock) begin
    int er, ec;
    if (resetn && px_valid2 && px_ready2) begin
      er = pix2 / 16;
      ec = pix2 % 16;
      check("s2_data", 32'(px_data2), 32'(er < 2 && ec < 2));
      check("s2_col", 32'(px_col2), 32'(ec));
      check("s2_row", 32'(px_row2), 32'(er));
      check("s2_eol", 32'(px_eol2), 32'(ec == 15));
      check("s2_last", 32'(px_last2), 32'(pix2 == 511));
      if (px_eol2) eol2++;
      pix2++;
    end
  end

  task automatic send(input logic [6:0] c);
    int n;
    @(posedge clock); #1;
    in_char = c;
    in_valid = 1'b1;
    @(negedge clock);
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) fail_to("accept");
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clock);
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) fail_to("glyph_done");
    @(negedge clock);
  endtask

  typedef struct {
    logic [6:0] ch;
    logic       tog;
    int         exp_pix;
    logic       chk_row2;
    logic [7:0] exp_row2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int a0, n;
    logic [7:0] r2;

    vecs[0] = '{7'h41, 1'b0, 128, 1'b1, 8'h38};
    vecs[1] = '{7'h41, 1'b1, 128, 1'b1, 8'h38};
    vecs[2] = '{7'h20, 1'b0, 128, 1'b1, 8'h00};
    vecs[3] = '{7'h7f, 1'b1, 128, 1'b0, 8'h00};
    vecs[4] = '{7'h5a, 1'b0, 128, 1'b0, 8'h00};

    #1 resetn = 1'b0;
    #11;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_px_valid", 32'(px_valid), 32'd0);
    check("rst_px_data", 32'(px_data), 32'd0);
    check("rst_px_col", 32'(px_col), 32'd0);
    check("rst_px_row", 32'(px_row), 32'd0);
    check("rst_px_eol", 32'(px_eol), 32'd0);
    check("rst_px_last", 32'(px_last), 32'd0);
    check("rst_glyph_char", 32'(glyph_char), 32'd0);
    check("rst2_px_valid", 32'(px_valid2), 32'd0);
    @(negedge clock); #2 resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      ready_mode = vecs[v].tog;
      send(vecs[v].ch);
      wait_done();
      ready_mode = 1'b0;
      check("vec_pix_count", 32'(pix_cnt), 32'(vecs[v].exp_pix));
      check("vec_last_count", 32'(last_cnt), 32'd1);
      check("vec_latency", 32'(first_cyc - acc_cyc), 32'd2);
      check("vec_glyph_char", 32'(glyph_char), 32'(vecs[v].ch));
      if (vecs[v].chk_row2) begin
        for (int k = 0; k < 8; k++) r2[7-k] = cap[16+k];
        check("vec_row2_pixels", 32'(r2), 32'(vecs[v].exp_row2));
      end
      repeat (2) @(negedge clock);
    end

    // Back-to-back: upstream holds in_valid through the first glyph.
    ready_mode = 1'b0;
    busy_ready = 0;
    a0 = acc_cnt;
    @(posedge clock); #1;
    in_char = 7'h41;
    in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 1000) begin @(negedge clock); n++; end
    @(posedge clock); #1;
    in_char = 7'h42;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 1000) begin @(negedge clock); n++; end
    if (acc_cnt < a0 + 2) fail_to("second_accept");
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clock);
    check("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
    check("b2b_ready_while_busy", 32'(busy_ready), 32'd0);
    check("b2b_gap", 32'(first_cyc - prev_last_cyc), 32'd3);
    check("b2b_glyph_char", 32'(glyph_char), 32'h42);
    check("b2b_pix_count", 32'(pix_cnt), 32'd128);

    // Reset in the middle of a glyph.
    send(7'h41);
    n = 0;
    while (pix_cnt < 40 && n < 1000) begin @(negedge clock); n++; end
    if (pix_cnt < 40) fail_to("pixel40");
    #2 resetn = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_px_valid", 32'(px_valid), 32'd0);
    check("midrst_px_col", 32'(px_col), 32'd0);
    check("midrst_px_row", 32'(px_row), 32'd0);
    check("midrst_glyph_char", 32'(glyph_char), 32'd0);
    @(negedge clock); #2 resetn = 1'b1;
    @(negedge clock);
    check("midrst_release_valid", 32'(px_valid), 32'd0);
    check("midrst_release_ready", 32'(in_ready), 32'd1);
    repeat (5) @(negedge clock);
    send(7'h43);
    wait_done();
    check("midrst_first_row", 32'(first_row), 32'd0);
    check("midrst_first_col", 32'(first_col), 32'd0);
    check("midrst_pix_count", 32'(pix_cnt), 32'd128);

`ifdef GLYPH_INVERT_EN
    in_invert = 1'b1;
    send(7'h20);
    in_invert = 1'b0;
    wait_done();
    check("invert_ones", 32'(ones_cnt), 32'd128);
`endif

    // SCALE=2 instance, single set bit at row 0 col 0.
    @(posedge clock); #1;
    in_char2 = 7'h41;
    in_valid2 = 1'b1;
    @(negedge clock);
    n = 0;
    while (!in_ready2 && n < 1000) begin @(negedge clock); n++; end
    @(posedge clock); #1;
    in_valid2 = 1'b0;
    n = 0;
    while (pix2 < 512 && n < 2000) begin @(negedge clock); n++; end
    if (pix2 < 512) fail_to("scale2_done");
    repeat (4) @(negedge clock);
    check("s2_pix_count", 32'(pix2), 32'd512);
    check("s2_eol_count", 32'(eol2), 32'd32);
    check("s2_in_ready", 32'(in_ready2), 32'd1);
    check("s2_glyph_char", 32'(glyph_char2), 32'h41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glyph_serializer.md
GLYPH_SERIALIZER -- requirements
Module: glyph_serializer

Interface
REQ-001 SHALL have parameter FONT_W, default 8, meaning glyph width in pixels (1..16).
REQ-002 SHALL have parameter FONT_H, default 16, meaning glyph height in pixel rows (1..32).
REQ-003 SHALL have parameter SCALE, default 1, meaning integer pixel replication factor, horizontal and vertical (1..4).
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all logic on rising edge.
REQ-005 SHALL have port resetn, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port in_char, input, 7, meaning ASCII code to render.
REQ-007 SHALL have port in_valid, input, 1, meaning in_char valid.
REQ-008 SHALL have port in_ready, output, 1, meaning block accepts a character.
REQ-009 SHALL have port glyph_char, output, 7, meaning code presented to the external glyph source.
REQ-010 SHALL have port glyph_bits, input, FONT_W*FONT_H, meaning combinational bitmap for glyph_char; MSB = row 0 col 0, row-major.
REQ-011 SHALL have port px_data, output, 1, meaning current pixel (1 = foreground).
REQ-012 SHALL have port px_valid, output, 1, meaning px_data valid.
REQ-013 SHALL have port px_ready, input, 1, meaning downstream accepts the pixel.
REQ-014 SHALL have port px_col, output, clog2(FONT_W*SCALE), meaning output column of current pixel.
REQ-015 SHALL have port px_row, output, clog2(FONT_H*SCALE), meaning output row of current pixel.
REQ-016 SHALL have port px_eol, output, 1, meaning current pixel is last of its output row.
REQ-017 SHALL have port px_last, output, 1, meaning current pixel is last of the glyph.

Function
REQ-018 SHALL implement states IDLE, LOAD, SHIFT; in_ready = 1 only in IDLE.
REQ-019 IDLE: in_valid & in_ready SHALL latch in_char into glyph_char and go to LOAD.
REQ-020 LOAD: SHALL capture glyph_bits into an internal bitmap register, clear all counters, go to SHIFT (one cycle).
REQ-021 SHIFT: px_valid SHALL be 1; a pixel transfers when px_valid & px_ready.
REQ-022 Pixel order SHALL be rows 0..FONT_H*SCALE-1, each row cols 0..FONT_W*SCALE-1; source bit = bitmap[row/SCALE][col/SCALE].
REQ-023 Each source row SHALL be emitted SCALE times consecutively; each source pixel SCALE times consecutively within a row.
REQ-024 px_eol SHALL be 1 when px_col = FONT_W*SCALE-1; px_last SHALL be 1 when additionally px_row = FONT_H*SCALE-1.
REQ-025 Transfer with px_last = 1 SHALL return to IDLE next cycle; total pixels per glyph = FONT_W*FONT_H*SCALE^2.
REQ-026 With px_ready = 0, px_data, px_col, px_row, px_eol, px_last SHALL hold stable.
REQ-027 in_valid while not in IDLE SHALL be ignored (no latch, no loss beyond normal valid/ready hold by upstream).
REQ-028 Acceptance-to-first-pixel latency SHALL be 2 cycles; minimum gap between glyphs (last pixel to next first pixel) SHALL be 3 cycles.
REQ-029 glyph_char SHALL hold its last latched value outside LOAD; glyph_bits SHALL be sampled only in LOAD.

Reset
REQ-030 resetn low SHALL asynchronously force IDLE, in_ready = 1 after release, px_valid = 0, px_data = 0, px_col = 0, px_row = 0, px_eol = 0, px_last = 0, glyph_char = 0, bitmap = 0.
REQ-031 Reset mid-glyph SHALL abort the glyph; no remaining pixels emitted after release.

Configuration
REQ-032 Macro GLYPH_INVERT_EN SHALL, when defined, add input in_invert (1 bit), latched with in_char, XOR-ing every px_data of that glyph; when undefined, port absent and px_data is the unmodified bitmap bit.

Verification
REQ-033 Reset, then in_char = 0x41 with glyph_bits row 2 = 8'h38, SCALE = 1, px_ready = 1 -> pixels 16..23 = 0,0,1,1,1,0,0,0; 128 pixels; px_last only on 128th.
REQ-034 Same glyph, px_ready toggled 1/0 every cycle -> identical 128-pixel sequence, outputs stable while px_ready = 0.
REQ-035 SCALE = 2, glyph with only row 0 col 0 set -> pixels at (row,col) (0,0),(0,1),(1,0),(1,1) = 1, others 0; 512 pixels; px_eol every 16th.
REQ-036 in_valid held during SHIFT with second char 0x42 -> in_ready = 0 until IDLE; 0x42 accepted exactly once after first px_last.
REQ-037 resetn pulsed low at pixel 40 -> px_valid = 0 immediately; after release, new char restarts at px_row = 0, px_col = 0.
REQ-038 GLYPH_INVERT_EN defined, in_invert = 1, space glyph (all 0) -> 128 pixels all 1.
